// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg: shared definitions for the LVDS receive frame controller.
//   state_t    - frame controller FSM states (IDLE, RECV)
//   CRC4_POLY  - CRC-4 polynomial x^4+x+1, top bit implied (4'h3)
//   CW_DEF     - default width of the saturating error counters
//   crc4_step  - advances a CRC-4 register by one nibble, MSB first
// Optional feature macro used by the consumers of this package: LVDS_RX_CRC_EN.
package lvds_rx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [3:0] CRC4_POLY = 4'h3;
  localparam int         CW_DEF    = 8;

  // Four bit-serial LFSR steps, most significant data bit first.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/lvds_rx_ctrl_if.sv
// lvds_rx_ctrl_if: DRU-side nibble stream, host-side frame handshake and
// error counters of the LVDS receive frame controller.
//   en, d, ds, dl        - receive enable, nibble, nibble strobe, last flag
//   o, ov, ordy          - frame data, frame valid, consumer ready
//   len_err, to_err,
//   ovf_err, crc_err     - saturating error counters
// Modports: slave = the frame controller, master = its environment.
// Handshake: a frame moves when ov and ordy are both 1 on a rising edge; while
// ov=1 and ordy=0 the controller holds o unchanged; ordy may be driven
// independently of ov.
interface lvds_rx_ctrl_if
  import lvds_rx_pkg::*;
#(
  parameter int NNIB = 10,
  parameter int CW   = CW_DEF
);
  logic                en;
  logic [3:0]          d;
  logic                ds;
  logic                dl;
  logic [4*NNIB-1:0]   o;
  logic                ov;
  logic                ordy;
  logic [CW-1:0]       len_err;
  logic [CW-1:0]       to_err;
  logic [CW-1:0]       ovf_err;
  logic [CW-1:0]       crc_err;

  modport master (
    output en, d, ds, dl, ordy,
    input  o, ov, len_err, to_err, ovf_err, crc_err
  );

  modport slave (
    input  en, d, ds, dl, ordy,
    output o, ov, len_err, to_err, ovf_err, crc_err
  );
endinterface

// File: rtl/lvds_crc4.sv
// lvds_crc4: nibble-serial CRC-4 (x^4+x+1, init 0).
//   c, r    - clock, synchronous active-high reset
//   i_clr   - restart from 0; combined with i_step the nibble is folded into 0
//   i_step  - fold i_nib into the register
//   i_nib   - data nibble
//   o_crc   - current CRC register
// Only built when LVDS_RX_CRC_EN is defined.
module lvds_crc4
  import lvds_rx_pkg::*;
(
  input  logic       c,
  input  logic       r,
  input  logic       i_clr,
  input  logic       i_step,
  input  logic [3:0] i_nib,
  output logic [3:0] o_crc
);
  logic [3:0] r_crc;
  logic [3:0] w_base;

  assign w_base = i_clr ? 4'h0 : r_crc;

  always_ff @(posedge c) begin
    if (r)           r_crc <= 4'h0;
    else if (i_step) r_crc <= crc4_step(w_base, i_nib);
    else if (i_clr)  r_crc <= 4'h0;
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/lvds_rx_ctrl.sv
// lvds_rx_ctrl: collects the DRU nibble stream into NNIB-nibble frames, checks
// length, inter-nibble timeout and (with LVDS_RX_CRC_EN) a trailing CRC-4, and
// offers good frames on a valid/ready output with saturating error counters.
//   c            - clock (DRU clock)
//   r            - synchronous active-high reset
//   bus          - lvds_rx_ctrl_if.slave (nibble input, frame output, counters)
//   o_dbg_state  - current FSM state for observation
// Parameters: NNIB nibbles per frame (first nibble most significant),
// TIMEOUT idle cycles allowed between nibbles, CW counter width.
// Macro: LVDS_RX_CRC_EN builds the CRC check; without it crc_err is 0.
module lvds_rx_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int NNIB    = 10,
  parameter int TIMEOUT = 64,
  parameter int CW      = CW_DEF
)(
  input  logic            c,
  input  logic            r,
  lvds_rx_ctrl_if.slave   bus,
  output state_t          o_dbg_state
);
  localparam int FW   = 4 * NNIB;
  localparam int CNTW = $clog2(NNIB + 2);
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_t          r_state, w_state_nxt;
  logic [FW-1:0]   r_asm, w_frame;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0]   r_timer;
  logic [FW-1:0]   r_o;
  logic            r_ov;
  logic [CW-1:0]   r_len_err, r_to_err, r_ovf_err;

  logic w_tmo_hit;
  logic w_shift, w_first, w_done, w_timeout, w_abort;
  logic w_len_ok, w_crc_ok, w_deliver, w_ovf, w_xfer;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CW'(1) : v;
  endfunction

  // Timer counts idle cycles since the last nibble; this cycle would be the
  // TIMEOUT-th one when it already holds TIMEOUT-1.
  assign w_tmo_hit = (r_timer == TW'(TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge c) begin
    if (r) r_state <= IDLE;
    else   r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.en && bus.ds && !bus.dl) w_state_nxt = RECV;
      RECV: if (!bus.en || (bus.ds && bus.dl) || (!bus.ds && w_tmo_hit)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (datapath strobes) ----------------
  always_comb begin
    w_shift   = 1'b0;
    w_first   = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en && bus.ds) begin
          w_shift = 1'b1;
          w_first = 1'b1;
          w_done  = bus.dl;
        end
      end
      RECV: begin
        // Dropping en wins over a nibble in the same cycle.
        if (!bus.en) begin
          w_abort = 1'b1;
        end else if (bus.ds) begin
          w_shift = 1'b1;
          w_done  = bus.dl;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

  // ---------------- Assembly datapath ----------------
  assign w_frame   = {r_asm[FW-5:0], bus.d};
  // Count saturates at NNIB+1 so any over-long frame still reads as bad.
  assign w_cnt_nxt = w_first ? CNTW'(1)
                   : ((r_cnt == CNTW'(NNIB + 1)) ? r_cnt : r_cnt + CNTW'(1));

  always_ff @(posedge c) begin
    if (r)            r_asm <= '0;
    else if (w_shift) r_asm <= w_frame;
  end

  always_ff @(posedge c) begin
    if (r)                                r_cnt <= '0;
    else if (w_done || w_timeout || w_abort) r_cnt <= '0;
    else if (w_shift)                     r_cnt <= w_cnt_nxt;
  end

  always_ff @(posedge c) begin
    if (r)
      r_timer <= '0;
    else if (r_state == RECV && !w_shift && !w_abort && !w_timeout)
      r_timer <= r_timer + TW'(1);
    else
      r_timer <= '0;
  end

  // ---------------- Optional CRC check ----------------
`ifdef LVDS_RX_CRC_EN
  logic [3:0]    w_crc;
  logic [CW-1:0] r_crc_err;

  // The final nibble is the received CRC, so it is compared, not folded in.
  lvds_crc4 u_crc (
    .c      (c),
    .r      (r),
    .i_clr  (w_first),
    .i_step (w_shift && !w_done),
    .i_nib  (bus.d),
    .o_crc  (w_crc)
  );

  assign w_crc_ok = (w_crc == bus.d);

  always_ff @(posedge c) begin
    if (r) r_crc_err <= '0;
    else   r_crc_err <= sat_inc(r_crc_err, w_done && w_len_ok && !w_crc_ok);
  end

  assign bus.crc_err = r_crc_err;
`else
  assign w_crc_ok    = 1'b1;
  assign bus.crc_err = '0;
`endif

  // ---------------- Frame output and handshake ----------------
  assign w_len_ok  = (w_cnt_nxt == CNTW'(NNIB));
  assign w_xfer    = r_ov && bus.ordy;
  // A transfer in the completion cycle frees the slot for the new frame.
  assign w_deliver = w_done && w_len_ok && w_crc_ok && (!r_ov || bus.ordy);
  assign w_ovf     = w_done && w_len_ok && w_crc_ok && r_ov && !bus.ordy;

  always_ff @(posedge c) begin
    if (r) begin
      r_o  <= '0;
      r_ov <= 1'b0;
    end else if (w_deliver) begin
      r_o  <= w_frame;
      r_ov <= 1'b1;
    end else if (w_xfer) begin
      r_ov <= 1'b0;
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      r_len_err <= '0;
      r_to_err  <= '0;
      r_ovf_err <= '0;
    end else begin
      r_len_err <= sat_inc(r_len_err, w_done && !w_len_ok);
      r_to_err  <= sat_inc(r_to_err, w_timeout);
      r_ovf_err <= sat_inc(r_ovf_err, w_ovf);
    end
  end

  assign bus.o       = r_o;
  assign bus.ov      = r_ov;
  assign bus.len_err = r_len_err;
  assign bus.to_err  = r_to_err;
  assign bus.ovf_err = r_ovf_err;
endmodule

// File: tb/tb_lvds_rx_ctrl.sv
// tb_lvds_rx_ctrl: directed bench for lvds_rx_ctrl. Stimulus pushes expected
// frames into exp_q; a negedge monitor pops and compares on every transfer.
// Define LVDS_RX_CRC_EN to exercise the CRC build.
module tb_lvds_rx_ctrl;
  import lvds_rx_pkg::*;

  localparam int NNIB    = 10;
  localparam int TIMEOUT = 64;
  localparam int CW      = 8;
  localparam int FW      = 4 * NNIB;

  // ---------------- clock / reset ----------------
  logic   c = 1'b0;
  logic   r;
  state_t dbg_state;

  always #5 c = ~c;

  lvds_rx_ctrl_if #(.NNIB(NNIB), .CW(CW)) bus ();

  lvds_rx_ctrl #(.NNIB(NNIB), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .c           (c),
    .r           (r),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_len = 0, exp_to = 0, exp_ovf = 0, exp_crc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".len_err"}, 64'(bus.len_err), 64'(exp_len));
    check({tag, ".to_err"},  64'(bus.to_err),  64'(exp_to));
    check({tag, ".ovf_err"}, 64'(bus.ovf_err), 64'(exp_ovf));
    check({tag, ".crc_err"}, 64'(bus.crc_err), 64'(exp_crc));
  endtask

`ifdef LVDS_RX_CRC_EN
  // Whole-message bit-serial CRC-4, x^4+x+1, init 0, MSB first.
  function automatic logic [3:0] tb_crc4(input logic [35:0] msg);
    logic [3:0] s;
    logic       fb;
    s = 4'h0;
    for (int i = 35; i >= 0; i--) begin
      fb = s[3] ^ msg[i];
      s  = {s[2:0], 1'b0};
      if (fb) s = s ^ 4'b0011;
    end
    return s;
  endfunction
`endif

  // A frame the DUT must accept: with CRC built, the last nibble becomes the CRC.
  function automatic logic [FW-1:0] make_good(input logic [FW-1:0] f);
`ifdef LVDS_RX_CRC_EN
    return {f[FW-1:4], tb_crc4(f[FW-1:4])};
`else
    return f;
`endif
  endfunction

  // ---------------- monitor ----------------
  logic [FW-1:0] held_o;
  logic          held_v = 1'b0;

  always @(negedge c) begin
    if (r === 1'b0) begin
      if (held_v && bus.ov) check("o_stable", 64'(bus.o), 64'(held_o));
      if (bus.ov && bus.ordy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h, expected no frame (t=%0t)", bus.o, $time);
        end else begin
          check("frame", 64'(bus.o), 64'(exp_q.pop_front()));
        end
      end
      held_v = bus.ov && !bus.ordy;
      held_o = bus.o;
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick(2);
    r = 1'b0;
    exp_len = 0; exp_to = 0; exp_ovf = 0; exp_crc = 0;
  endtask

  // One nibble held for one cycle, then `gap` cycles with ds low.
  task automatic send_nib(input logic [3:0] nib, input logic last, input int gap);
    bus.d  = nib;
    bus.ds = 1'b1;
    bus.dl = last;
    tick(1);
    bus.ds = 1'b0;
    bus.dl = 1'b0;
    tick(gap);
  endtask

  // Sends the low n nibbles of f, most significant first.
  task automatic send_frame(input logic [63:0] f, input int n, input int gap,
                            input logic with_dl, input logic ordy_last);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && ordy_last) bus.ordy = 1'b1;
      send_nib(f[4*(n-1-i) +: 4], with_dl && (i == n - 1), gap);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [FW-1:0] f1, fa, fb, fc, fd, fe, fg;

  initial begin
    r = 1'b1;
    bus.en = 1'b1; bus.d = 4'h0; bus.ds = 1'b0; bus.dl = 1'b0; bus.ordy = 1'b1;
    tick(2);
    do_reset();

    // Reset state
    check("rst.ov", 64'(bus.ov), 64'd0);
    check("rst.o", 64'(bus.o), 64'd0);
    check("rst.state", 64'(dbg_state), 64'(IDLE));
    check_counters("rst");

    // Good frame 1..A, ds every other cycle, 1-cycle latency, 1-cycle valid
    f1 = make_good(40'h123456789A);
    exp_q.push_back(f1);
    send_frame(64'(f1 >> 4), 9, 1, 1'b0, 1'b0);
    send_nib(f1[3:0], 1'b1, 0);
    @(negedge c);
    check("good.ov_rise", 64'(bus.ov), 64'd1);
    @(negedge c);
    check("good.ov_pulse", 64'(bus.ov), 64'd0);
    tick(1);
    check_counters("good");

    // Short frame (5), long frame (11), single-nibble frame, then a good one
    send_frame(64'h12345, 5, 1, 1'b1, 1'b0);
    exp_len++;
    send_frame(64'h123456789AB, 11, 1, 1'b1, 1'b0);
    exp_len++;
    send_nib(4'h7, 1'b1, 1);
    exp_len++;
    fa = make_good(40'hA1B2C3D4E5);
    exp_q.push_back(fa);
    send_frame(64'(fa), NNIB, 1, 1'b1, 1'b0);
    tick(2);
    check_counters("len");

    // Consecutive-cycle nibbles, next frame starting right after completion
    fa = make_good(40'h0F1E2D3C4B);
    fb = make_good(40'h5A697887A6);
    exp_q.push_back(fa);
    exp_q.push_back(fb);
    send_frame(64'(fa), NNIB, 0, 1'b1, 1'b0);
    send_frame(64'(fb), NNIB, 0, 1'b1, 1'b0);
    tick(2);
    check_counters("b2b");

    // Backpressure: A held, B overflows, then A transfers
    bus.ordy = 1'b0;
    fa = make_good(40'hAAAA5555AA);
    fb = make_good(40'hBBBB6666BB);
    exp_q.push_back(fa);
    send_frame(64'(fa), NNIB, 1, 1'b1, 1'b0);
    send_frame(64'(fb), NNIB, 1, 1'b1, 1'b0);
    exp_ovf++;
    tick(2);
    check("bp.ov_held", 64'(bus.ov), 64'd1);
    check("bp.o_held", 64'(bus.o), 64'(fa));
    check_counters("bp");
    bus.ordy = 1'b1;
    tick(2);
    check("bp.ov_clear", 64'(bus.ov), 64'd0);

    // Transfer and completion in the same cycle: no overflow
    bus.ordy = 1'b0;
    fc = make_good(40'hC0C1C2C3C4);
    fd = make_good(40'hD0D1D2D3D4);
    exp_q.push_back(fc);
    exp_q.push_back(fd);
    send_frame(64'(fc), NNIB, 1, 1'b1, 1'b0);
    send_frame(64'(fd), NNIB, 1, 1'b1, 1'b1);
    tick(2);
    check_counters("xfer_load");

    // Timeout after 3 nibbles: fires on the TIMEOUT-th idle cycle
    send_frame(64'h321, 3, 1, 1'b0, 1'b0);
    tick(TIMEOUT - 2);
    check("to.before_state", 64'(dbg_state), 64'(RECV));
    check("to.before_cnt", 64'(bus.to_err), 64'(exp_to));
    tick(1);
    exp_to++;
    check("to.state", 64'(dbg_state), 64'(IDLE));
    check_counters("to");
    fe = make_good(40'h13579BDF02);
    exp_q.push_back(fe);
    send_frame(64'(fe), NNIB, 1, 1'b1, 1'b0);
    tick(2);

    // Reset mid-frame with a held frame: both discarded, counters cleared
    bus.ordy = 1'b0;
    send_frame(64'(make_good(40'hDEADBEEF12)), NNIB, 1, 1'b1, 1'b0);
    check("rstmid.held", 64'(bus.ov), 64'd1);
    send_frame(64'h4321, 4, 1, 1'b0, 1'b0);
    do_reset();
    bus.ordy = 1'b1;
    check("rstmid.ov", 64'(bus.ov), 64'd0);
    check("rstmid.state", 64'(dbg_state), 64'(IDLE));
    check_counters("rstmid");
    fg = make_good(40'h2468ACE135);
    exp_q.push_back(fg);
    send_frame(64'(fg), NNIB, 1, 1'b1, 1'b0);
    tick(2);

    // en dropped mid-frame: silent abort
    send_frame(64'h8765, 4, 1, 1'b0, 1'b0);
    bus.en = 1'b0;
    tick(1);
    bus.en = 1'b1;
    check("en.state", 64'(dbg_state), 64'(IDLE));
    fg = make_good(40'h97531ECA86);
    exp_q.push_back(fg);
    send_frame(64'(fg), NNIB, 1, 1'b1, 1'b0);
    tick(2);
    check_counters("en");

`ifdef LVDS_RX_CRC_EN
    // Correct CRC delivered; flipped CRC nibble rejected
    fg = make_good(40'h0123456789);
    exp_q.push_back(fg);
    send_frame(64'(fg), NNIB, 1, 1'b1, 1'b0);
    tick(2);
    send_frame(64'(fg ^ 40'h1), NNIB, 1, 1'b1, 1'b0);
    exp_crc++;
    tick(1);
    check("crc.ov", 64'(bus.ov), 64'd0);
    check_counters("crc");
`endif

    // Drain: every expected frame must have appeared, bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_rx_ctrl.md
# lvds_rx_ctrl

Frame controller downstream of the LVDS data recovery unit. Collects the recovered nibble stream into fixed-length frames and validates frame length, inter-nibble timeout and, optionally, a CRC-4. Presents good frames to the host side over a valid/ready handshake and keeps saturating error counters. Sits between the DRU output register and the register/bus logic of the LVDS target.

## Interface
Parameters:
- NNIB, 10: nibbles per frame; first nibble received is most significant.
- TIMEOUT, 64: maximum idle cycles between nibbles inside a frame.
- CW, 8: width of each error counter.

Ports:
- c  in  1  clock, 400 MHz, same clock as the DRU.
- r  in  1  reset; synchronous, active-high.
- en  in  1  receive enable; when 0, incoming nibbles are ignored.
- d  in  4  nibble from the DRU.
- ds  in  1  nibble strobe; d is valid for exactly this cycle.
- dl  in  1  last-nibble flag; qualified by ds.
- o  out  4*NNIB  frame data.
- ov  out  1  frame valid.
- ordy  in  1  consumer ready.
- len_err  out  CW  count of short or long frames.
- to_err  out  CW  count of timeouts.
- ovf_err  out  CW  count of frames dropped because the output was occupied.
- crc_err  out  CW  count of CRC failures; constant 0 when CRC is not compiled in.

## Operation
- Reset values: o=0, ov=0, all counters 0, state IDLE, nibble count 0, timer 0.
- IDLE:
  - Entered on reset and after any frame completes or aborts.
  - On ds and en: shift d into the assembly register, set count=1, clear the timer, go to RECV.
  - If dl is set on that same nibble, handle it as a completed frame of length 1.
- RECV:
  - Each ds shifts d into the assembly register as {asm[4*NNIB-5:0], d}, increments count (saturating at NNIB+1) and clears the timer.
  - Cycles without ds increment the timer.
  - When the timer reaches TIMEOUT: to_err++ and go to IDLE. Partial data is discarded.
  - en falling while in RECV aborts the frame silently: go to IDLE, no counter changes.
- Frame completion (ds and dl together), the completed frame is checked in this order:
  - Final count ≠ NNIB: len_err++, drop.
  - CRC compiled in and check fails: crc_err++, drop.
  - ov=1 and ordy=0 in that cycle: ovf_err++, drop. The held frame is kept.
  - Otherwise: o takes the assembled frame, ov=1.
  - In every case, go to IDLE.
- Handshake:
  - Transfer happens when ov and ordy are both 1; ov clears on the next edge unless a new frame loads in the same cycle.
  - If a transfer and a frame completion occur in the same cycle, the new frame loads, ov stays 1 and no overflow is counted.
  - o is stable while ov=1 and ordy=0.
- Counters saturate at 2^CW−1 and never wrap.
- A reset mid-frame discards the partial frame and any held output.

## Timing
- ov rises on the edge after the ds/dl cycle, giving 1-cycle latency from the last nibble.
- A new frame may start on the cycle immediately after completion, since IDLE accepts ds on its first cycle.
- Counter increments are visible one cycle after the triggering event.
- ds arrives at most every other cycle (DRU nibble rate); the block must nevertheless accept ds on consecutive cycles.

## Configuration
- LVDS_RX_CRC_EN defined:
  - The last nibble of each frame is a CRC-4, polynomial x^4+x+1, init 0, computed nibble-serially over the first NNIB−1 nibbles.
  - A frame passes when the CRC register matches the received CRC nibble.
  - Failures increment crc_err and the frame is dropped.
  - o still carries all NNIB nibbles, including the CRC nibble.
- LVDS_RX_CRC_EN undefined: no CRC logic is built, every nibble is payload, and crc_err is tied to 0.

## Structure
- Shared package lvds_rx_pkg holds:
  - the state enum (IDLE, RECV);
  - the CRC-4 polynomial constant 4'h3;
  - the default CW.
- One sub-module, lvds_crc4: a nibble-serial CRC-4 with clear, step and 4-bit state output. It is instantiated only under LVDS_RX_CRC_EN.

## Test plan
- Good frame, CRC off, ordy=1: nibbles 1..A on ds every 2 cycles, dl on the 10th → o=40'h123456789A, ov=1 for 1 cycle, one cycle after the last ds; all counters 0.
- Short frame of 5 nibbles with dl on the 5th, then a good frame → len_err=1 and only the second frame appears on o.
- Backpressure: ordy=0, two good frames A and B → o holds A, ovf_err=1; raising ordy transfers A and ov clears.
- Timeout: 3 nibbles, then no ds for TIMEOUT cycles → to_err=1, back to IDLE; the next good frame is delivered intact.
- Reset mid-frame after 4 nibbles, then a good frame → no errors counted, ov only for the good frame. Repeat with en deasserted mid-frame and expect the same result.
- With LVDS_RX_CRC_EN: a frame with correct CRC → delivered. The same frame with the last nibble flipped → crc_err=1, ov stays 0.
